// File: rtl/ps2_pkg.sv
// ps2_pkg
// Shared definitions for the PS/2 keyboard receiver: set-2 scan-code
// constants used by the key decoder and the frame FSM state encoding.
// No ports.
package ps2_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_ENTER = 8'h5A;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rxState_e;

endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx
// Conditions the raw PS/2 clock/data lines (2-flop synchronizers plus a
// glitch filter on the clock) and receives 11-bit frames: start, 8 data
// bits LSB first, odd parity, stop. A mid-frame stall longer than
// TIMEOUT_CYCLES aborts the frame.
// Ports:
//   clk_i        system clock
//   rst_i        asynchronous active-high reset
//   ps2_clk_i    raw PS/2 clock, asynchronous, idle high
//   ps2_data_i   raw PS/2 data, asynchronous, idle high
//   rx_byte_o    last correctly received byte
//   rx_valid_o   one-cycle pulse when rx_byte_o updates
//   frame_err_o  one-cycle pulse on parity/stop/timeout error
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] rx_byte_o,
    output logic       rx_valid_o,
    output logic       frame_err_o
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    clkSync_q;
    logic [1:0]    dataSync_q;
    logic          filtClk_q;
    logic [FW-1:0] filtCnt_q;
    logic          fall_q;

    rxState_e      state_q;
    logic [2:0]    bitCnt_q;
    logic [7:0]    shift_q;
    logic          parity_q;
    logic [7:0]    rxByte_q;
    logic          rxValid_q;
    logic          frameErr_q;
    logic [TW-1:0] timer_q;

    logic          dataBit;

    assign dataBit = dataSync_q[1];

    // The filtered clock only follows the synchronized clock after
    // FILTER_LEN consecutive samples disagree with it; a falling edge is
    // flagged for one cycle when it flips to 0.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            clkSync_q  <= 2'b11;
            dataSync_q <= 2'b11;
            filtClk_q  <= 1'b1;
            filtCnt_q  <= '0;
            fall_q     <= 1'b0;
        end else begin
            clkSync_q  <= {clkSync_q[0], ps2_clk_i};
            dataSync_q <= {dataSync_q[0], ps2_data_i};
            fall_q     <= 1'b0;
            if (clkSync_q[1] == filtClk_q) begin
                filtCnt_q <= '0;
            end else if (filtCnt_q == FW'(FILTER_LEN - 1)) begin
                filtClk_q <= clkSync_q[1];
                filtCnt_q <= '0;
                fall_q    <= ~clkSync_q[1];
            end else begin
                filtCnt_q <= filtCnt_q + 1'b1;
            end
        end
    end

    // Frame FSM with registered pulses. The stall timer only runs while a
    // frame is in progress and restarts on every falling edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            bitCnt_q   <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            rxByte_q   <= '0;
            rxValid_q  <= 1'b0;
            frameErr_q <= 1'b0;
            timer_q    <= '0;
        end else begin
            rxValid_q  <= 1'b0;
            frameErr_q <= 1'b0;
            if (state_q == ST_IDLE) begin
                timer_q <= '0;
                if (fall_q && !dataBit) begin
                    state_q  <= ST_DATA;
                    bitCnt_q <= '0;
                end
            end else if (fall_q) begin
                timer_q <= '0;
                unique case (state_q)
                    ST_DATA: begin
                        shift_q  <= {dataBit, shift_q[7:1]};
                        bitCnt_q <= bitCnt_q + 3'd1;
                        if (bitCnt_q == 3'd7) begin
                            state_q <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        parity_q <= dataBit;
                        state_q  <= ST_STOP;
                    end
                    ST_STOP: begin
                        // Odd parity: data plus parity bit hold an odd count of 1s.
                        if (dataBit && (^{shift_q, parity_q})) begin
                            rxByte_q  <= shift_q;
                            rxValid_q <= 1'b1;
                        end else begin
                            frameErr_q <= 1'b1;
                        end
                        state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                frameErr_q <= 1'b1;
                state_q    <= ST_IDLE;
                timer_q    <= '0;
            end else begin
                timer_q <= timer_q + 1'b1;
            end
        end
    end

    assign rx_byte_o   = rxByte_q;
    assign rx_valid_o  = rxValid_q;
    assign frame_err_o = frameErr_q;

endmodule

// File: rtl/ps2_key_rx.sv
// ps2_key_rx
// PS/2 keyboard receiver for the game controls. Receives frames through
// ps2_frame_rx and turns set-2 make/break sequences into held-key levels.
// Ports:
//   clk_i        system clock, 100 MHz
//   rst_i        asynchronous active-high reset
//   ps2_clk_i    raw PS/2 clock, idle high
//   ps2_data_i   raw PS/2 data, idle high
//   rx_byte_o    last correctly received byte
//   rx_valid_o   one-cycle pulse when rx_byte_o updates
//   frame_err_o  one-cycle pulse on a receive error
//   key_left_o   left arrow (E0 6B) held
//   key_right_o  right arrow (E0 74) held
//   key_pause_o  space (29) held
//   key_start_o  enter (5A) held
module ps2_key_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] rx_byte_o,
    output logic       rx_valid_o,
    output logic       frame_err_o,
    output logic       key_left_o,
    output logic       key_right_o,
    output logic       key_pause_o,
    output logic       key_start_o
);

    logic [7:0] rxByte;
    logic       rxValid;
    logic       frameErr;

    logic ext_q;
    logic brk_q;
    logic left_q;
    logic right_q;
    logic pause_q;
    logic start_q;

    ps2_frame_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) uFrameRx (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .ps2_clk_i   (ps2_clk_i),
        .ps2_data_i  (ps2_data_i),
        .rx_byte_o   (rxByte),
        .rx_valid_o  (rxValid),
        .frame_err_o (frameErr)
    );

    // Prefix flags are consumed by the next key code. The arrow codes only
    // count when extended and space/enter only when not extended, so the
    // keypad keys sharing those codes are ignored. A receive error drops
    // any pending prefix but leaves the key levels alone.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ext_q   <= 1'b0;
            brk_q   <= 1'b0;
            left_q  <= 1'b0;
            right_q <= 1'b0;
            pause_q <= 1'b0;
            start_q <= 1'b0;
        end else if (rxValid) begin
            if (rxByte == SC_EXT) begin
                ext_q <= 1'b1;
            end else if (rxByte == SC_BRK) begin
                brk_q <= 1'b1;
            end else begin
                if (ext_q && rxByte == SC_LEFT) begin
                    left_q <= ~brk_q;
                end
                if (ext_q && rxByte == SC_RIGHT) begin
                    right_q <= ~brk_q;
                end
                if (!ext_q && rxByte == SC_SPACE) begin
                    pause_q <= ~brk_q;
                end
                if (!ext_q && rxByte == SC_ENTER) begin
                    start_q <= ~brk_q;
                end
                ext_q <= 1'b0;
                brk_q <= 1'b0;
            end
        end else if (frameErr) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
        end
    end

    assign rx_byte_o   = rxByte;
    assign rx_valid_o  = rxValid;
    assign frame_err_o = frameErr;
    assign key_left_o  = left_q;
    assign key_right_o = right_q;
    assign key_pause_o = pause_q;
    assign key_start_o = start_q;

endmodule
